pause_fader: RTL and testbench

Parametrised successor to the core-level pause block. It merges any number of pause requesters with the user pause button and the OSD-open pause, and drives the registered `pause_cpu` strobe. After a configurable idle delay it fades the video in stepped right-shifts instead of a single dim level. It sits between the core's RGB expansion and `arcade_video`, in the `clk_sys` domain.

---
 rtl/pause_pkg.sv | 26 ++
 rtl/pause_ms_tick.sv | 32 +++
 rtl/pause_fader.sv | 134 +++++++++++++
 tb/tb_pause_fader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pause_pkg.sv
// Shared types and helpers for the pause/fade block: dim FSM states,
// the prescaler terminal count and a saturating logical right shift.
package pause_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        FADE
    } dim_state_t;

    // Terminal value of the millisecond prescaler for a clock of clkspd MHz.
    function automatic int unsigned ms_term(input int unsigned clkspd);
        return clkspd * 1000 - 1;
    endfunction

    // Logical right shift of a width-bit value; shifting by width or more gives 0.
    function automatic logic [31:0] shr_sat(input logic [31:0] val,
                                            input int unsigned shift,
                                            input int unsigned width);
        if (shift >= width) begin
            return '0;
        end
        return val >> shift;
    endfunction

endpackage

// File: rtl/pause_ms_tick.sv
// Millisecond prescaler: counts clk_sys cycles while enabled and emits a
// one-cycle tick every CLKSPD*1000 cycles; clr restarts it from zero.
module pause_ms_tick
    import pause_pkg::*;
#(
    parameter int CLKSPD = 40
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned TERM = ms_term(CLKSPD);
    localparam int CW = $clog2(TERM + 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == CW'(TERM));

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk_sys) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pause_fader.sv
// Merges pause sources into the registered pause_cpu strobe and, after an idle
// delay while user-paused, fades the RGB video in stepped right shifts.
module pause_fader
    import pause_pkg::*;
#(
    parameter int RW         = 3,
    parameter int GW         = 3,
    parameter int BW         = 3,
    parameter int CLKSPD     = 40,
    parameter int NREQ       = 1,
    parameter int DIM_MS     = 10000,
    parameter int FADE_MS    = 250,
    parameter int FADE_STEPS = 3
) (
    input  logic                              clk_sys,
    input  logic                              reset,
    input  logic                              user_button,
    input  logic [NREQ-1:0]                   pause_request,
    input  logic                              OSD_STATUS,
    input  logic [1:0]                        options,
    input  logic [RW-1:0]                     r,
    input  logic [GW-1:0]                     g,
    input  logic [BW-1:0]                     b,
    output logic                              pause_cpu,
    output logic [$clog2(FADE_STEPS+1)-1:0]   dim_level,
    output logic [RW+GW+BW-1:0]               rgb_out
);

    localparam int DW     = $clog2(FADE_STEPS + 1);
    localparam int MS_MAX = (DIM_MS > FADE_MS) ? DIM_MS : FADE_MS;
    localparam int MW     = $clog2(MS_MAX + 1);

    logic                btn_q;
    logic                pause_toggle_q;
    logic                pause_cpu_q;
    dim_state_t          state_q, state_d;
    logic [DW-1:0]       dim_q, dim_d;
    logic [MW-1:0]       ms_q, ms_d;
    logic [RW+GW+BW-1:0] rgb_q;

    logic          pause_src_user;
    logic          go_idle;
    logic          ms_tick;
    logic [RW-1:0] r_sh;
    logic [GW-1:0] g_sh;
    logic [BW-1:0] b_sh;

    assign pause_src_user = pause_toggle_q | (options[0] & OSD_STATUS);
    assign go_idle        = ~pause_src_user | ~options[1];

    pause_ms_tick #(
        .CLKSPD(CLKSPD)
    ) u_ms_tick (
        .clk_sys(clk_sys),
        .reset  (reset),
        .en_i   (state_q != IDLE),
        .clr_i  (state_q == IDLE),
        .tick_o (ms_tick)
    );

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        dim_d   = dim_q;
        ms_d    = ms_q;
        unique case (state_q)
            IDLE: begin
                dim_d = '0;
                ms_d  = '0;
                if (!go_idle) state_d = COUNT;
            end
            COUNT: begin
                if (ms_tick) begin
                    if (ms_q == MW'(DIM_MS - 1)) begin
                        state_d = FADE;
                        dim_d   = DW'(1);
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end
            FADE: begin
                if (ms_tick) begin
                    if (ms_q == MW'(FADE_MS - 1)) begin
                        ms_d = '0;
                        if (dim_q != DW'(FADE_STEPS)) dim_d = dim_q + 1'b1;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Losing the user pause or the dim enable beats any pending fade step.
        if (go_idle) begin
            state_d = IDLE;
            dim_d   = '0;
            ms_d    = '0;
        end
    end

    always_comb begin
        r_sh = RW'(shr_sat(32'(r), 32'(dim_q), RW));
        g_sh = GW'(shr_sat(32'(g), 32'(dim_q), GW));
        b_sh = BW'(shr_sat(32'(b), 32'(dim_q), BW));
    end

    always_ff @(posedge clk_sys) begin
        // Loaded even in reset so a button held through reset never toggles.
        btn_q <= user_button;
        if (reset) begin
            pause_toggle_q <= 1'b0;
            pause_cpu_q    <= 1'b0;
            state_q        <= IDLE;
            dim_q          <= '0;
            ms_q           <= '0;
            rgb_q          <= '0;
        end else begin
            if (user_button && !btn_q) pause_toggle_q <= ~pause_toggle_q;
            pause_cpu_q <= pause_src_user | (|pause_request);
            state_q     <= state_d;
            dim_q       <= dim_d;
            ms_q        <= ms_d;
            rgb_q       <= {r_sh, g_sh, b_sh};
        end
    end

    assign pause_cpu = pause_cpu_q;
    assign dim_level = dim_q;
    assign rgb_out   = rgb_q;

endmodule

// File: tb/tb_pause_fader.sv
// Randomised self-checking bench for pause_fader against a cycle-count model
// of the pause latency and fade schedule.
module tb_pause_fader;

    localparam int CLKSPD     = 1;
    localparam int DIM_MS     = 4;
    localparam int FADE_MS    = 2;
    localparam int FADE_STEPS = 3;
    localparam int NREQ       = 2;
    localparam int CPM        = CLKSPD * 1000;
    // Edge index (counting the toggling edge as 0) of the first fade step.
    localparam int FIRST      = 1 + DIM_MS * CPM;
    localparam int STEP       = FADE_MS * CPM;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            user_button;
    logic [NREQ-1:0] pause_request;
    logic            OSD_STATUS;
    logic [1:0]      options;
    logic [2:0]      r, g, b;
    logic            pause_cpu;
    logic [1:0]      dim_level;
    logic [8:0]      rgb_out;

    int tests = 0;
    int fails = 0;

    pause_fader #(
        .RW(3), .GW(3), .BW(3),
        .CLKSPD(CLKSPD), .NREQ(NREQ),
        .DIM_MS(DIM_MS), .FADE_MS(FADE_MS), .FADE_STEPS(FADE_STEPS)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .user_button  (user_button),
        .pause_request(pause_request),
        .OSD_STATUS   (OSD_STATUS),
        .options      (options),
        .r            (r),
        .g            (g),
        .b            (b),
        .pause_cpu    (pause_cpu),
        .dim_level    (dim_level),
        .rgb_out      (rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int model_dim(input int n);
        int d;
        if (n < FIRST) return 0;
        d = 1 + (n - FIRST) / STEP;
        return (d > FADE_STEPS) ? FADE_STEPS : d;
    endfunction

    function automatic bit near_step(input int n);
        for (int k = 0; k < FADE_STEPS; k++) begin
            if (n >= FIRST + k * STEP - 1 && n <= FIRST + k * STEP + 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int faded(input logic [8:0] pix, input int d);
        logic [2:0] rr, gg, bb;
        rr = pix[8:6] >> d;
        gg = pix[5:3] >> d;
        bb = pix[2:0] >> d;
        return int'({rr, gg, bb});
    endfunction

    task automatic drive_rgb_random(output logic [8:0] pix);
        pix = 9'($urandom);
        {r, g, b} = pix;
    endtask

    task automatic test_reset();
        reset = 1'b1; user_button = 1'b1; pause_request = '0;
        OSD_STATUS = 1'b0; options = 2'b00; {r, g, b} = 9'h1FF;
        repeat (3) step();
        check("reset_pause_cpu", int'(pause_cpu), 0);
        check("reset_dim", int'(dim_level), 0);
        check("reset_rgb", int'(rgb_out), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("held_button_no_toggle", int'(pause_cpu), 0);
        end
        user_button = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_button_latency();
        user_button = 1'b1;
        step();
        check("btn_edge_plus1", int'(pause_cpu), 0);
        step();
        check("btn_edge_plus2", int'(pause_cpu), 1);
        user_button = 1'b0;
        repeat (3) step();
        check("btn_held_paused", int'(pause_cpu), 1);
        user_button = 1'b1;
        step();
        check("btn_unpause_plus1", int'(pause_cpu), 1);
        user_button = 1'b0;
        step();
        check("btn_unpause_plus2", int'(pause_cpu), 0);
    endtask

    task automatic test_request();
        options = 2'b10;
        for (int i = 0; i < 5000; i++) begin
            pause_request = NREQ'($urandom_range(1, 3));
            step();
            check("req_pause_cpu", int'(pause_cpu), 1);
            check("req_no_dim", int'(dim_level), 0);
        end
        // A button edge while a request is active still toggles.
        user_button = 1'b1;
        step();
        pause_request = '0; user_button = 1'b0;
        step();
        check("req_btn_toggled", int'(pause_cpu), 1);
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        step();
        check("req_btn_untoggled", int'(pause_cpu), 0);
        check("req_btn_dim", int'(dim_level), 0);
    endtask

    task automatic test_fade();
        logic [8:0] cur;
        options = 2'b11; OSD_STATUS = 1'b0;
        drive_rgb_random(cur);
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        for (int n = 1; n <= 9000; n++) begin
            OSD_STATUS = 1'($urandom);
            drive_rgb_random(cur);
            step();
            check("fade_pause_cpu", int'(pause_cpu), 1);
            if (!near_step(n)) check("fade_dim", int'(dim_level), model_dim(n));
            if (!near_step(n - 1)) check("fade_rgb", int'(rgb_out), faded(cur, model_dim(n - 1)));
        end
        check("fade_saturated", int'(dim_level), FADE_STEPS);
        user_button = 1'b1;
        OSD_STATUS = 1'b0;
        drive_rgb_random(cur);
        step();
        check("unpause_plus1_cpu", int'(pause_cpu), 1);
        check("unpause_plus1_rgb", int'(rgb_out), faded(cur, FADE_STEPS));
        user_button = 1'b0;
        step();
        check("unpause_plus2_cpu", int'(pause_cpu), 0);
        check("unpause_plus2_dim", int'(dim_level), 0);
        drive_rgb_random(cur);
        step();
        check("unpause_rgb_full", int'(rgb_out), int'(cur));
    endtask

    task automatic test_osd();
        logic [8:0] cur;
        options = 2'b11;
        OSD_STATUS = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive_rgb_random(cur);
            step();
            check("osd_pause_cpu", int'(pause_cpu), 1);
            check("osd_no_dim", int'(dim_level), 0);
            check("osd_rgb", int'(rgb_out), int'(cur));
        end
        OSD_STATUS = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            check("osd_closed_cpu", int'(pause_cpu), 0);
            check("osd_closed_dim", int'(dim_level), 0);
        end
    endtask

    task automatic test_reset_mid_fade();
        options = 2'b10; {r, g, b} = 9'h1FF;
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        for (int n = 1; n <= 7000; n++) step();
        check("mid_fade_dim2", int'(dim_level), 2);
        reset = 1'b1; user_button = 1'b1;
        step();
        check("midreset_cpu", int'(pause_cpu), 0);
        check("midreset_dim", int'(dim_level), 0);
        check("midreset_rgb", int'(rgb_out), 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_reset_cpu", int'(pause_cpu), 0);
            check("post_reset_dim", int'(dim_level), 0);
        end
        user_button = 1'b0;
        repeat (2) step();
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        for (int n = 1; n <= FIRST + 2; n++) begin
            step();
            if (n == FIRST - 2) check("restart_before_step", int'(dim_level), 0);
            if (n == FIRST + 2) check("restart_after_step", int'(dim_level), 1);
        end
    endtask

    initial begin
        test_reset();
        test_button_latency();
        test_request();
        test_fade();
        test_osd();
        test_reset_mid_fade();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
